regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised next-generation register file for the pipeline ID stage.
//  - N registered read ports, one write port with write-to-read bypass.
//  - Replaces 32 parallel debug buses with a serial dump port (valid/ready)
//    that streams every register to the UART debug path, one per beat.
// PARAMETERS
//  DATA_WIDTH      32  register width in bits
//  ADDR_WIDTH      5   address width; DEPTH = 2**ADDR_WIDTH registers
//  NUM_READ_PORTS  2   number of independent read ports (>=1)
// PORTS
//  clock       in   1                          single clock, rising edge
//  reset       in   1                          asynchronous, active-high
//  read_addr   in   NUM_READ_PORTS*ADDR_WIDTH  port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  read_data   out  NUM_READ_PORTS*DATA_WIDTH  port p at [p*DATA_WIDTH +: DATA_WIDTH]
//  reg_write   in   1                          1 = write write_data at write_address
//  write_address in ADDR_WIDTH                 write target
//  write_data  in   DATA_WIDTH                 write value
//  dump_start  in   1                          pulse: begin streaming all registers
//  dump_ready  in   1                          consumer accepts current beat
//  dump_valid  out  1                          dump_addr/dump_data are valid
//  dump_addr   out  ADDR_WIDTH                 index of register being presented
//  dump_data   out  DATA_WIDTH                 value of that register
//  dump_busy   out  1                          dump FSM not IDLE
//  dump_done   out  1                          one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (async, while reset=1): all storage = 0; read_data = 0; dump_valid,
//   dump_busy, dump_done = 0; dump_addr = 0; dump_data = 0; FSM -> IDLE.
//  Write: on clock edge when reg_write=1, storage[write_address] <= write_data.
//  Read: 1-cycle latency; read_data[p] registered every edge from read_addr[p].
//   Bypass: if reg_write and write_address == read_addr[p] on the same edge,
//   read_data[p] gets write_data (write-first). All ports independent.
//  Dump FSM states IDLE, SEND, DONE:
//   IDLE: dump_start=1 -> SEND; idx=0; dump_data loaded with storage[0]
//    (with same-edge write bypass), dump_valid=1.
//   SEND: dump_valid=1; outputs held stable while dump_ready=0.
//    dump_valid&dump_ready & idx<DEPTH-1 -> idx+1, load next value (bypassed).
//    dump_valid&dump_ready & idx==DEPTH-1 -> DONE, dump_valid=0.
//   DONE: dump_done=1 for exactly one cycle -> IDLE.
//  Snapshot rule: each beat's value is sampled when loaded; later writes to
//   that address do not change the presented dump_data.
//  dump_start while busy (SEND/DONE): ignored, no restart.
//  Dump never stalls normal reads/writes; all ops proceed concurrently.
//  reset asserted mid-dump: FSM aborts to IDLE, no dump_done pulse.
//  idx never wraps: terminal count DEPTH-1 ends the dump.
// CONFIGURATION
//  REGFILE_ZERO_REG_EN defined: register 0 hardwired to zero. Writes to address 0
//   discarded; no bypass for address 0; reads and dump of address 0 return 0.
//  REGFILE_ZERO_REG_EN undefined: register 0 is an ordinary read/write register.
// STRUCTURE
//  Package regfile_pkg: dump FSM state encoding (IDLE/SEND/DONE) and
//   default width constants shared with the UART debug block.
//  Sub-module regfile_dump_fsm: state register, idx counter, handshake and
//   done pulse; top holds storage, read ports, bypass muxes.
// TESTING
//  1 Reset: drive reset=1 mid-run -> all read_data=0, dump_valid=0, read of
//    any address after release =0.
//  2 Write 0x0000_00AA to r7, next cycle read port0=7 -> read_data[0]=0xAA after 1 clk.
//  3 Bypass: reg_write r9=0x1234 and read_addr port1=9 same edge -> 0x1234 next cycle.
//  4 Dump: preload r1=10, r3=15, r15=20; pulse dump_start, ready=1 -> 32 beats
//    addr 0..31 with those values, then dump_done 1 cycle, dump_busy=0.
//  5 Backpressure: ready toggles 0/1 and write r2=0x55 after beat 2 loaded ->
//    data stable during stalls, beat 2 shows old value, dump_start mid-dump ignored.
//  6 REGFILE_ZERO_REG_EN: write r0=0xFFFF_FFFF -> read and dump of r0 = 0;
//    without macro -> 0xFFFF_FFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: dump FSM state encoding and default widths shared with the UART debug block
package regfile_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ_PORTS = 2;
  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;
endpackage

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: streams every register index in order over a valid/ready port, then pulses done
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  dump_state_t state;
  // The top resolves load_addr (with write bypass) into load_data for the next beat.
  assign load_addr = (state == IDLE) ? '0 : dump_addr + 1'b1;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dump_start) begin
          state      <= SEND;
          dump_addr  <= '0;
          dump_data  <= load_data;
          dump_valid <= 1'b1;
          dump_busy  <= 1'b1;
        end
        SEND: if (dump_ready) begin
          if (dump_addr == LAST) begin
            state      <= DONE;
            dump_valid <= 1'b0;
            dump_done  <= 1'b1;
          end else begin
            dump_addr <= load_addr;
            dump_data <= load_data;
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_busy <= 1'b0;
          dump_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: N registered read ports, one bypassed write port, serial dump; define REGFILE_ZERO_REG_EN to hardwire r0 to zero
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ_PORTS = DEFAULT_NUM_READ_PORTS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
  input  logic                                 reg_write,
  input  logic [ADDR_WIDTH-1:0]                write_address,
  input  logic [DATA_WIDTH-1:0]                write_data,
  input  logic                                 dump_start,
  input  logic                                 dump_ready,
  output logic                                 dump_valid,
  output logic [ADDR_WIDTH-1:0]                dump_addr,
  output logic [DATA_WIDTH-1:0]                dump_data,
  output logic                                 dump_busy,
  output logic                                 dump_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q [NUM_READ_PORTS];
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  we;
  // With r0 hardwired, mem[0] is never written and resets to 0, so gating we removes both the write and its bypass.
  assign we = reg_write && !(ZERO_REG && write_address == '0);
  function automatic logic [DATA_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] a);
    return (we && write_address == a) ? write_data : mem[a];
  endfunction
  assign load_data = lookup(load_addr);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[write_address] <= write_data;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_READ_PORTS; i++) rd_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_READ_PORTS; i++) rd_q[i] <= lookup(read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
  end
  regfile_dump_fsm #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dump (
    .clock      (clock),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .load_data  (load_data),
    .load_addr  (load_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: random and directed stimulus against a behavioural register-file model via a scoreboard queue
module tb_regfile_multiport;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset;
  logic [NP*AW-1:0] read_addr;
  logic [NP*DW-1:0] read_data;
  logic reg_write;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic dump_start, dump_ready, dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;

  regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NP)) dut (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(read_data),
    .reg_write(reg_write), .write_address(write_address), .write_data(write_data),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int tag;
    logic [NP*DW-1:0] rd;
    logic v, b, d;
    logic [AW-1:0] a;
    logic [DW-1:0] dd;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [DEPTH];
  int ph;
  int idx;
  logic [DW-1:0] md;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] val(input int a, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (ZERO && a == 0) return '0;
    if (w && int'(wa) == a) return wd;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    ph = 0;
    idx = 0;
    md = '0;
    q.delete();
  endtask

  task automatic step(input logic rw, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic st, input logic rdy);
    exp_t e;
    logic w;
    @(negedge clock);
    reg_write = rw;
    write_address = wa;
    write_data = wd;
    read_addr = {r1, r0};
    dump_start = st;
    dump_ready = rdy;
    w = rw && !(ZERO && wa == 0);
    e.tag = cyc + 1;
    e.rd = {val(int'(r1), w, wa, wd), val(int'(r0), w, wa, wd)};
    if (ph == 0) begin
      if (st) begin
        ph = 1;
        idx = 0;
        md = val(0, w, wa, wd);
      end
    end else if (ph == 1) begin
      if (rdy) begin
        if (idx == DEPTH - 1) ph = 2;
        else begin
          idx++;
          md = val(idx, w, wa, wd);
        end
      end
    end else ph = 0;
    e.v = (ph == 1);
    e.b = (ph != 0);
    e.d = (ph == 2);
    e.a = AW'(idx);
    e.dd = md;
    q.push_back(e);
    if (w) model[wa] = wd;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    reg_write = 1'b0;
    dump_start = 1'b0;
    clear_model();
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        chk("reset_read_data", 64'(read_data), 64'd0);
        chk("reset_dump_valid", 64'(dump_valid), 64'd0);
        chk("reset_dump_busy", 64'(dump_busy), 64'd0);
        chk("reset_dump_done", 64'(dump_done), 64'd0);
      end else if (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        chk("read_data", 64'(read_data), 64'(e.rd));
        chk("dump_valid", 64'(dump_valid), 64'(e.v));
        chk("dump_busy", 64'(dump_busy), 64'(e.b));
        chk("dump_done", 64'(dump_done), 64'(e.d));
        if (e.v) begin
          chk("dump_addr", 64'(dump_addr), 64'(e.a));
          chk("dump_data", 64'(dump_data), 64'(e.dd));
        end
      end
    end
  end

  initial begin
    bit wrote2;
    reset = 1'b1;
    reg_write = 1'b0;
    write_address = '0;
    write_data = '0;
    read_addr = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    step(1, 5'd7, 32'hAA, 5'd0, 5'd0, 0, 0);
    step(0, 5'd0, 32'h0, 5'd7, 5'd0, 0, 0);
    step(1, 5'd9, 32'h1234, 5'd0, 5'd9, 0, 0);
    step(0, 5'd0, 32'h0, 5'd9, 5'd9, 0, 0);
    step(1, 5'd1, 32'd10, 5'd1, 5'd3, 0, 0);
    step(1, 5'd3, 32'd15, 5'd1, 5'd3, 0, 0);
    step(1, 5'd15, 32'd20, 5'd15, 5'd3, 0, 0);
    step(0, 5'd0, 32'h0, 5'd15, 5'd1, 1, 1);
    repeat (36) step(0, 5'd0, 32'h0, AW'($urandom), AW'($urandom), 0, 1);
    wrote2 = 0;
    step(0, 5'd0, 32'h0, 5'd2, 5'd2, 1, 0);
    for (int i = 0; i < 90; i++) begin
      if (ph == 1 && idx == 2 && !wrote2) begin
        wrote2 = 1;
        step(1, 5'd2, 32'h55, 5'd2, 5'd2, 0, 0);
      end else step(0, 5'd0, 32'h0, 5'd2, AW'($urandom), i == 20, 1'(i % 2));
    end
    repeat (4) step(0, 5'd0, 32'h0, 5'd2, 5'd0, 0, 0);
    step(1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 0);
    step(0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 1);
    repeat (36) step(0, 5'd0, 32'h0, 5'd0, AW'($urandom), 0, 1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(0, 5'd0, 32'h0, 5'd1, 5'd2, 1, 0);
        repeat (5) step(1, AW'($urandom), $urandom, AW'($urandom), AW'($urandom), 0, 1);
        do_reset(2);
      end else begin
        step(1'($urandom), AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
             ($urandom % 16) == 0, 1'($urandom));
      end
    end
    repeat (3) @(negedge clock);
    #2;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
